// File: rtl/imm_seq_pkg.sv
// Shared encodings for the immediate-instruction sequencer: opcodes,
// ALU operation codes and the sequencer state type.
package imm_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LIT  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_ANDI = 4'h4;
  localparam logic [3:0] OP_ORI  = 4'h5;
  localparam logic [3:0] OP_CMPI = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_PASS = 3'd4;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_OPERAND = 3'd3,
    S_HALT    = 3'd4
  } seq_state_t;

  // Two-byte instructions whose second byte is a jump target.
  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JC) || (op == OP_JZ);
  endfunction

endpackage

// File: rtl/imm_seq_decode.sv
// Pure combinational opcode decode: datapath enables for an instruction
// as they would apply in its EXEC cycle, plus the undefined-opcode flag.
module imm_seq_decode
  import imm_seq_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] i_op,
  output logic            o_imm_sel,
  output logic [2:0]      o_alu_op,
  output logic            o_acc_load,
  output logic            o_flags_load,
  output logic            o_undef
);

  // Opcode to enables; defaults describe a NOP.
  always_comb begin
    o_imm_sel    = 1'b0;
    o_alu_op     = ALU_ADD;
    o_acc_load   = 1'b0;
    o_flags_load = 1'b0;
    o_undef      = 1'b0;
    case (i_op)
      OP_LIT: begin
        o_imm_sel  = 1'b1;
        o_alu_op   = ALU_PASS;
        o_acc_load = 1'b1;
      end
      OP_ADDI: begin o_alu_op = ALU_ADD; o_acc_load = 1'b1; o_flags_load = 1'b1; end
      OP_SUBI: begin o_alu_op = ALU_SUB; o_acc_load = 1'b1; o_flags_load = 1'b1; end
      OP_ANDI: begin o_alu_op = ALU_AND; o_acc_load = 1'b1; o_flags_load = 1'b1; end
      OP_ORI:  begin o_alu_op = ALU_OR;  o_acc_load = 1'b1; o_flags_load = 1'b1; end
      OP_CMPI: begin o_alu_op = ALU_SUB; o_flags_load = 1'b1; end
      OP_NOP, OP_JMP, OP_JC, OP_JZ, OP_HALT: ;
      default: o_undef = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_seq_ctrl.sv
// Fetch/decode/execute sequencer: owns PC and IR, issues one-cycle
// accumulator/flag strobes in EXEC and resolves two-byte jumps in OPERAND.
module imm_seq_ctrl
  import imm_seq_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  input  logic [7:0]      rom_data,
  input  logic            carry,
  input  logic            zero,
  output logic [PC_W-1:0] rom_addr,
  output logic [3:0]      imm,
  output logic            imm_sel,
  output logic [2:0]      alu_op,
  output logic            acc_load,
  output logic            flags_load,
  output logic            halted,
  output logic            illegal
);

  seq_state_t      r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [7:0]      r_ir, w_ir_nxt;
  logic            r_illegal, w_illegal_nxt;

  logic [OP_W-1:0] w_op;
  logic            w_dec_imm_sel, w_dec_acc_load, w_dec_flags_load, w_dec_undef;
  logic [2:0]      w_dec_alu_op;
  logic            w_taken;
  logic            w_in_exec;

  assign w_op = r_ir[7 -: OP_W];

  imm_seq_decode #(.OP_W(OP_W)) u_decode (
    .i_op         (w_op),
    .o_imm_sel    (w_dec_imm_sel),
    .o_alu_op     (w_dec_alu_op),
    .o_acc_load   (w_dec_acc_load),
    .o_flags_load (w_dec_flags_load),
    .o_undef      (w_dec_undef)
  );

  // Flags are only consulted here, in the OPERAND cycle.
  assign w_taken = (w_op == OP_JMP) ||
                   ((w_op == OP_JC) && carry) ||
                   ((w_op == OP_JZ) && zero);

  // State, PC, IR and sticky illegal registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  // Next-state logic; run is only looked at in FETCH, HALT is terminal.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_illegal_nxt = r_illegal;
    case (r_state)
      S_FETCH: begin
        if (run) begin
          w_ir_nxt    = rom_data;
          w_pc_nxt    = r_pc + 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_dec_undef) w_illegal_nxt = 1'b1;
        if (is_jump(4'(w_op)))      w_state_nxt = S_OPERAND;
        else if (w_op == OP_HALT)   w_state_nxt = S_HALT;
        else                        w_state_nxt = S_EXEC;
      end
      S_EXEC: w_state_nxt = S_FETCH;
      S_OPERAND: begin
        // Not taken still consumes the operand byte (wraps at the top).
        w_pc_nxt    = w_taken ? PC_W'(rom_data) : r_pc + 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Strobes derive from state + IR only, so reset removes them at once.
  assign w_in_exec  = (r_state == S_EXEC);
  assign imm_sel    = w_in_exec & w_dec_imm_sel;
  assign alu_op     = w_in_exec ? w_dec_alu_op : ALU_ADD;
  assign acc_load   = w_in_exec & w_dec_acc_load;
  assign flags_load = w_in_exec & w_dec_flags_load;
  assign rom_addr   = r_pc;
  assign imm        = r_ir[3:0];
  assign halted     = (r_state == S_HALT);
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_imm_seq_ctrl.sv
// Directed bench for imm_seq_ctrl with a behavioural 256-byte program ROM.
module tb_imm_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic       carry = 1'b0;
  logic       zero = 1'b0;
  logic [7:0] rom_data;
  logic [7:0] rom_addr;
  logic [3:0] imm;
  logic       imm_sel;
  logic [2:0] alu_op;
  logic       acc_load;
  logic       flags_load;
  logic       halted;
  logic       illegal;

  logic [7:0] rom [256];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  imm_seq_ctrl #(.PC_W(8), .OP_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .rom_data   (rom_data),
    .carry      (carry),
    .zero       (zero),
    .rom_addr   (rom_addr),
    .imm        (imm),
    .imm_sel    (imm_sel),
    .alu_op     (alu_op),
    .acc_load   (acc_load),
    .flags_load (flags_load),
    .halted     (halted),
    .illegal    (illegal)
  );

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  // Hold reset for two edges and release on a falling edge.
  task automatic apply_reset(input logic run_val);
    reset_n = 1'b0;
    run = run_val;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 8'h15;
    reset_n = 1'b0;
    run = 1'b1;
    step(2);
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL rst_pc got=%0h want=0", rom_addr); end
    total++; if ({imm_sel, acc_load, flags_load, halted, illegal} !== 5'b0) begin bad++; $display("FAIL rst_outs got=%b want=00000", {imm_sel, acc_load, flags_load, halted, illegal}); end
    total++; if (alu_op !== 3'd0) begin bad++; $display("FAIL rst_alu got=%0d want=0", alu_op); end
  endtask

  task automatic test_lit();
    clear_rom();
    rom[0] = 8'h15;
    apply_reset(1'b1);
    step(1);
    total++; if (acc_load !== 1'b0) begin bad++; $display("FAIL lit_decode_nostrobe got=%b want=0", acc_load); end
    step(1);
    total++; if ({imm_sel, acc_load, flags_load} !== 3'b110) begin bad++; $display("FAIL lit_strobes got=%b want=110", {imm_sel, acc_load, flags_load}); end
    total++; if (imm !== 4'd5) begin bad++; $display("FAIL lit_imm got=%0d want=5", imm); end
    total++; if (alu_op !== 3'd4) begin bad++; $display("FAIL lit_alu got=%0d want=4", alu_op); end
    total++; if (rom_addr !== 8'h01) begin bad++; $display("FAIL lit_pc got=%0h want=1", rom_addr); end
    step(1);
    total++; if ({imm_sel, acc_load} !== 2'b00) begin bad++; $display("FAIL lit_one_cycle got=%b want=00", {imm_sel, acc_load}); end
  endtask

  task automatic test_back_to_back();
    clear_rom();
    rom[0] = 8'h23;
    rom[1] = 8'h63;
    apply_reset(1'b1);
    step(2);
    total++; if ({acc_load, flags_load, imm_sel} !== 3'b110 || alu_op !== 3'd0) begin bad++; $display("FAIL addi got=%b/%0d want=110/0", {acc_load, flags_load, imm_sel}, alu_op); end
    step(3);
    total++; if ({acc_load, flags_load} !== 2'b01 || alu_op !== 3'd1) begin bad++; $display("FAIL cmpi got=%b/%0d want=01/1", {acc_load, flags_load}, alu_op); end
    total++; if (rom_addr !== 8'h02) begin bad++; $display("FAIL cmpi_pc got=%0h want=2", rom_addr); end
    clear_rom();
    rom[0] = 8'h41;
    rom[1] = 8'h52;
    rom[2] = 8'h37;
    apply_reset(1'b1);
    step(2);
    total++; if (alu_op !== 3'd2 || acc_load !== 1'b1) begin bad++; $display("FAIL andi got=%0d/%b want=2/1", alu_op, acc_load); end
    step(3);
    total++; if (alu_op !== 3'd3 || imm !== 4'd2) begin bad++; $display("FAIL ori got=%0d/%0d want=3/2", alu_op, imm); end
    step(3);
    total++; if (alu_op !== 3'd1 || {acc_load, flags_load} !== 2'b11) begin bad++; $display("FAIL subi got=%0d/%b want=1/11", alu_op, {acc_load, flags_load}); end
  endtask

  task automatic test_jumps();
    clear_rom();
    rom[0] = 8'h90;
    rom[1] = 8'h40;
    zero = 1'b1;
    apply_reset(1'b1);
    step(2);
    total++; if ({acc_load, flags_load} !== 2'b00) begin bad++; $display("FAIL jz_operand_nostrobe got=%b want=00", {acc_load, flags_load}); end
    step(1);
    total++; if (rom_addr !== 8'h40) begin bad++; $display("FAIL jz_taken got=%0h want=40", rom_addr); end
    zero = 1'b0;
    apply_reset(1'b1);
    step(3);
    total++; if (rom_addr !== 8'h02) begin bad++; $display("FAIL jz_not_taken got=%0h want=02", rom_addr); end
  endtask

  task automatic test_wrap();
    // JMP 0xFE, then JMP 0x10 located at 0xFE.
    clear_rom();
    rom[0] = 8'h70; rom[1] = 8'hFE;
    rom[8'hFE] = 8'h70; rom[8'hFF] = 8'h10;
    apply_reset(1'b1);
    step(3);
    total++; if (rom_addr !== 8'hFE) begin bad++; $display("FAIL jmp_fe got=%0h want=fe", rom_addr); end
    step(3);
    total++; if (rom_addr !== 8'h10) begin bad++; $display("FAIL jmp_top got=%0h want=10", rom_addr); end
    // NOP at 0xFF: fetch increment wraps to 0.
    clear_rom();
    rom[0] = 8'h70; rom[1] = 8'hFF; rom[8'hFF] = 8'h00;
    apply_reset(1'b1);
    step(6);
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL nop_wrap got=%0h want=00", rom_addr); end
    // JC not taken at 0xFE: operand skip wraps to 0.
    clear_rom();
    rom[0] = 8'h70; rom[1] = 8'hFE; rom[8'hFE] = 8'h80; rom[8'hFF] = 8'h33;
    carry = 1'b0;
    apply_reset(1'b1);
    step(6);
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL skip_wrap got=%0h want=00", rom_addr); end
    carry = 1'b1;
    apply_reset(1'b1);
    step(6);
    total++; if (rom_addr !== 8'h33) begin bad++; $display("FAIL jc_taken got=%0h want=33", rom_addr); end
    carry = 1'b0;
  endtask

  task automatic test_illegal_halt();
    clear_rom();
    rom[0] = 8'hB0;
    rom[1] = 8'hF0;
    apply_reset(1'b1);
    step(1);
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill_early got=%b want=0", illegal); end
    step(1);
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_set got=%b want=1", illegal); end
    total++; if ({imm_sel, acc_load, flags_load} !== 3'b000) begin bad++; $display("FAIL ill_nostrobe got=%b want=000", {imm_sel, acc_load, flags_load}); end
    step(3);
    total++; if (halted !== 1'b1 || rom_addr !== 8'h02) begin bad++; $display("FAIL halt_enter got=%b/%0h want=1/02", halted, rom_addr); end
    step(20);
    total++; if (halted !== 1'b1 || rom_addr !== 8'h02 || illegal !== 1'b1) begin bad++; $display("FAIL halt_hold got=%b/%0h/%b want=1/02/1", halted, rom_addr, illegal); end
    total++; if ({acc_load, flags_load} !== 2'b00) begin bad++; $display("FAIL halt_nostrobe got=%b want=00", {acc_load, flags_load}); end
  endtask

  task automatic test_run_hold();
    clear_rom();
    rom[0] = 8'h15;
    apply_reset(1'b0);
    step(5);
    total++; if (rom_addr !== 8'h00 || acc_load !== 1'b0) begin bad++; $display("FAIL run_hold got=%0h/%b want=00/0", rom_addr, acc_load); end
    @(negedge clk);
    run = 1'b1;
    step(1);
    run = 1'b0;
    step(1);
    total++; if (acc_load !== 1'b1) begin bad++; $display("FAIL run_drop_exec got=%b want=1", acc_load); end
    step(3);
    total++; if (rom_addr !== 8'h01 || acc_load !== 1'b0) begin bad++; $display("FAIL run_drop_hold got=%0h/%b want=01/0", rom_addr, acc_load); end
  endtask

  task automatic test_mid_reset();
    clear_rom();
    rom[0] = 8'hA0;
    rom[1] = 8'h25;
    apply_reset(1'b1);
    step(5);
    total++; if (acc_load !== 1'b1 || illegal !== 1'b1) begin bad++; $display("FAIL pre_reset got=%b/%b want=1/1", acc_load, illegal); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if ({acc_load, flags_load, imm_sel} !== 3'b000) begin bad++; $display("FAIL async_drop got=%b want=000", {acc_load, flags_load, imm_sel}); end
    total++; if (rom_addr !== 8'h00 || illegal !== 1'b0) begin bad++; $display("FAIL async_clear got=%0h/%b want=00/0", rom_addr, illegal); end
    run = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(3);
    total++; if (rom_addr !== 8'h00 || halted !== 1'b0) begin bad++; $display("FAIL post_reset_fetch got=%0h/%b want=00/0", rom_addr, halted); end
  endtask

  initial begin
    test_reset();
    test_lit();
    test_back_to_back();
    test_jumps();
    test_wrap();
    test_illegal_halt();
    test_run_hold();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
